// File: rtl/intt_pkg.sv
// Shared constants and types for the INTT stage scheduler and its address generator.
package intt_pkg;

    localparam int unsigned N      = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned Q      = 8380417;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;
    } slot_t;

endpackage

// File: rtl/intt_addr_gen.sv
// Gentleman-Sande address generator: stage/pair/group counters and the derived
// butterfly addresses and twiddle index for the current pair.
module intt_addr_gen #(
    parameter int unsigned N      = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] a_o,
    output logic [ADDR_W-1:0] b_o,
    output logic [ADDR_W-1:0] tw_o,
    output logic              last_in_stage_o,
    output logic              last_stage_o
);
    import intt_pkg::*;

    localparam int unsigned S_W = $clog2(ADDR_W);

    logic [S_W-1:0]    s_q;
    logic [ADDR_W-2:0] i_q;
    logic [ADDR_W-2:0] g_q;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] j;
    logic              grp_end;

    // g is kept as its own counter so i>>s never needs a barrel shifter.
    always_comb begin
        len             = ADDR_W'(1) << s_q;
        j               = {1'b0, i_q} & (len - 1'b1);
        a_o             = (({1'b0, g_q} << s_q) << 1) | j;
        b_o             = a_o + len;
        tw_o            = ADDR_W'((N >> s_q) - 1) - {1'b0, g_q};
        grp_end         = (j == (len - 1'b1));
        last_in_stage_o = (i_q == (ADDR_W-1)'(N/2 - 1));
        last_stage_o    = (s_q == S_W'(ADDR_W - 1));
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s_q <= '0;
            i_q <= '0;
            g_q <= '0;
        end else if (clear_i) begin
            s_q <= '0;
            i_q <= '0;
            g_q <= '0;
        end else if (adv_i) begin
            if (last_in_stage_o) begin
                i_q <= '0;
                g_q <= '0;
                s_q <= last_stage_o ? '0 : s_q + 1'b1;
            end else begin
                i_q <= i_q + 1'b1;
                if (grp_end) begin
                    g_q <= g_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/intt_stage_sched.sv
// In-place 256-point inverse NTT sequencer: read pair, register into the
// butterfly, write results back two cycles later; drains between stages.
module intt_stage_sched #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N          = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    rd_en_o,
    output logic [ADDR_W-1:0]       rd_addr_a_o,
    output logic [ADDR_W-1:0]       rd_addr_b_o,
    input  logic [DATA_WIDTH-1:0]   rd_data_a_i,
    input  logic [DATA_WIDTH-1:0]   rd_data_b_i,
    output logic [ADDR_W-1:0]       tw_addr_o,
    input  logic [DATA_WIDTH-1:0]   tw_data_i,
    output logic [2*DATA_WIDTH-1:0] bu_data1_o,
    output logic [2*DATA_WIDTH-1:0] bu_data2_o,
    output logic [DATA_WIDTH-1:0]   bu_w_o,
    input  logic [DATA_WIDTH-1:0]   bu_data1_i,
    input  logic [DATA_WIDTH-1:0]   bu_data2_i,
    output logic                    wr_en_o,
    output logic [ADDR_W-1:0]       wr_addr_a_o,
    output logic [ADDR_W-1:0]       wr_addr_b_o,
    output logic [DATA_WIDTH-1:0]   wr_data_a_o,
    output logic [DATA_WIDTH-1:0]   wr_data_b_o
);
    import intt_pkg::*;

    state_e                  state_q;
    logic                    drain_q;
    logic                    final_q;
    logic                    rd_en_q;
    logic                    busy_q;
    logic                    done_q;
    slot_t                   slot1_q;
    slot_t                   slot2_q;
    logic [2*DATA_WIDTH-1:0] bu1_q;
    logic [2*DATA_WIDTH-1:0] bu2_q;
    logic [DATA_WIDTH-1:0]   buw_q;

    logic [ADDR_W-1:0]       gen_a;
    logic [ADDR_W-1:0]       gen_b;
    logic [ADDR_W-1:0]       gen_tw;
    logic                    last_in_stage;
    logic                    last_stage;

    intt_addr_gen #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .clear_i         (state_q == ST_IDLE),
        .adv_i           (rd_en_q),
        .a_o             (gen_a),
        .b_o             (gen_b),
        .tw_o            (gen_tw),
        .last_in_stage_o (last_in_stage),
        .last_stage_o    (last_stage)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            drain_q <= 1'b0;
            final_q <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= ST_RUN;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_in_stage) begin
                        state_q <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                        drain_q <= 1'b0;
                        final_q <= last_stage;
                    end
                end
                ST_DRAIN: begin
                    // Two idle cycles let the last write of the stage land before the next read.
                    if (drain_q) begin
                        if (final_q) begin
                            state_q <= ST_FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            slot1_q <= '0;
            slot2_q <= '0;
            bu1_q   <= '0;
            bu2_q   <= '0;
            buw_q   <= '0;
        end else begin
            slot1_q <= '{valid: rd_en_q, addr_a: rd_addr_a_o, addr_b: rd_addr_b_o};
            slot2_q <= slot1_q;
            if (slot1_q.valid) begin
                bu1_q <= {{DATA_WIDTH{1'b0}}, rd_data_a_i};
                bu2_q <= {{DATA_WIDTH{1'b0}}, rd_data_b_i};
                buw_q <= tw_data_i;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_a_o = rd_en_q ? gen_a  : '0;
    assign rd_addr_b_o = rd_en_q ? gen_b  : '0;
    assign tw_addr_o   = rd_en_q ? gen_tw : '0;
    assign bu_data1_o  = bu1_q;
    assign bu_data2_o  = bu2_q;
    assign bu_w_o      = buw_q;
    assign wr_en_o     = slot2_q.valid;
    assign wr_addr_a_o = slot2_q.addr_a;
    assign wr_addr_b_o = slot2_q.addr_b;
    assign wr_data_a_o = slot2_q.valid ? bu_data1_i : '0;
    assign wr_data_b_o = slot2_q.valid ? bu_data2_i : '0;

endmodule

// File: tb/tb_intt_stage_sched.sv
// Scoreboard bench for intt_stage_sched with a behavioural RAM, twiddle ROM and
// Gentleman-Sande butterfly.
module tb_intt_stage_sched;

    localparam int QM = 8380417;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, rd_en_o, wr_en_o;
    logic [7:0]  rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;
    logic [31:0] rd_data_a_i = '0, rd_data_b_i = '0, tw_data_i = '0;
    logic [63:0] bu_data1_o, bu_data2_o;
    logic [31:0] bu_w_o, bu_data1_i, bu_data2_i, wr_data_a_o, wr_data_b_o;

    always #5 clk_i = ~clk_i;

    intt_stage_sched #(.DATA_WIDTH(32), .N(256), .ADDR_W(8)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
        .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
        .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
        .tw_addr_o(tw_addr_o), .tw_data_i(tw_data_i),
        .bu_data1_o(bu_data1_o), .bu_data2_o(bu_data2_o), .bu_w_o(bu_w_o),
        .bu_data1_i(bu_data1_i), .bu_data2_i(bu_data2_i),
        .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
        .wr_data_a_o(wr_data_a_o), .wr_data_b_o(wr_data_b_o)
    );

    function automatic logic [31:0] bf1(input logic [31:0] x, input logic [31:0] y);
        return 32'((64'(x) + 64'(y)) % 64'(QM));
    endfunction

    function automatic logic [31:0] bf2(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w);
        longint d;
        d = (longint'(x) - longint'(y) + longint'(QM)) % longint'(QM);
        return 32'((d * longint'(w)) % longint'(QM));
    endfunction

    function automatic logic [31:0] pat_val(input int p, input int k);
        return (p == 0) ? 32'(k) : 32'((k * k * 31 + 5) % QM);
    endfunction

    assign bu_data1_i = bf1(bu_data1_o[31:0], bu_data2_o[31:0]);
    assign bu_data2_i = bf2(bu_data1_o[31:0], bu_data2_o[31:0], bu_w_o);

    logic [31:0] mem [256];
    logic [31:0] twrom [256];
    logic [31:0] gold [256];
    logic        load_req = 1'b0;
    int          pat = 0;

    always @(posedge clk_i) begin
        if (load_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= pat_val(pat, k);
        end else if (wr_en_o) begin
            mem[wr_addr_a_o] <= wr_data_a_o;
            mem[wr_addr_b_o] <= wr_data_b_o;
        end
        if (rd_en_o) begin
            rd_data_a_i <= mem[rd_addr_a_o];
            rd_data_b_i <= mem[rd_addr_b_o];
        end
        tw_data_i <= twrom[tw_addr_o];
    end

    typedef struct { int cyc; int a; int b; int tw; } rd_exp_t;
    typedef struct { int cyc; int a; int b; longint d1; longint d2; } wr_exp_t;
    rd_exp_t rdq[$];
    wr_exp_t wrq[$];

    // Hand-derived reads: (cycle, a, b, tw)
    int tbl_cyc [7] = '{1, 2, 128, 131, 132, 911, 1038};
    int tbl_a   [7] = '{0, 2, 254, 0, 1, 0, 127};
    int tbl_b   [7] = '{1, 3, 255, 2, 3, 128, 255};
    int tbl_tw  [7] = '{255, 254, 128, 127, 127, 1, 1};

    int n_vec = 0, n_err = 0;
    int cnt = 0, t0 = 1 << 30, mon_rel = 0;
    int wr_cnt = 0, done_seen = 0, tbl_hits = 0, run_id = 0;
    logic mon_en = 1'b0, run_active = 1'b0;
    rd_exp_t re;
    wr_exp_t we;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", nm, act, exp, mon_rel, $time);
        end
    endtask

    task automatic build_expected();
        logic [31:0] x, y, w;
        int len, a, b, tw, c;
        for (int k = 0; k < 256; k++) gold[k] = mem[k];
        for (int s = 0; s < 8; s++) begin
            len = 1 << s;
            for (int grp = 0; grp < (128 >> s); grp++) begin
                for (int j = 0; j < len; j++) begin
                    a  = grp * 2 * len + j;
                    b  = a + len;
                    tw = (256 >> s) - 1 - grp;
                    c  = 1 + 130 * s + grp * len + j;
                    x = gold[a]; y = gold[b]; w = twrom[tw];
                    gold[a] = bf1(x, y);
                    gold[b] = bf2(x, y, w);
                    rdq.push_back('{c, a, b, tw});
                    wrq.push_back('{c + 2, a, b, longint'(gold[a]), longint'(gold[b])});
                end
            end
        end
    endtask

    always @(posedge clk_i) cnt <= cnt + 1;

    always @(posedge clk_i) begin
        #1;
        mon_rel = cnt + 1 - t0;
        if (mon_en) begin
            if (rd_en_o) begin
                if (rdq.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    re = rdq.pop_front();
                    chk("rd_cycle", mon_rel, re.cyc);
                    chk("rd_addr_a", rd_addr_a_o, re.a);
                    chk("rd_addr_b", rd_addr_b_o, re.b);
                    chk("tw_addr", tw_addr_o, re.tw);
                end
                for (int k = 0; k < 7; k++) begin
                    if (mon_rel == tbl_cyc[k]) begin
                        tbl_hits++;
                        chk("tbl_rd_a", rd_addr_a_o, tbl_a[k]);
                        chk("tbl_rd_b", rd_addr_b_o, tbl_b[k]);
                        chk("tbl_tw", tw_addr_o, tbl_tw[k]);
                    end
                end
            end
            if (wr_en_o) begin
                wr_cnt++;
                if (wrq.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    we = wrq.pop_front();
                    chk("wr_cycle", mon_rel, we.cyc);
                    chk("wr_addr_a", wr_addr_a_o, we.a);
                    chk("wr_addr_b", wr_addr_b_o, we.b);
                    chk("wr_data_a", wr_data_a_o, we.d1);
                    chk("wr_data_b", wr_data_b_o, we.d2);
                    chk("bu_zero_ext", {bu_data1_o[63:32], bu_data2_o[63:32]}, 0);
                end
                if (run_id == 1 && mon_rel == 3) begin
                    chk("first_wr_a", wr_addr_a_o, 0);
                    chk("first_wr_b", wr_addr_b_o, 1);
                    chk("first_wr_d1", wr_data_a_o, 1);
                    chk("first_wr_d2", wr_data_b_o, QM - 1);
                end
            end
            if (done_o) begin
                done_seen++;
                chk("done_cycle", mon_rel, 1041);
                chk("busy_at_done", busy_o, 0);
            end
            if (run_active && (mon_rel == 1 || mon_rel == 1040)) chk("busy_high", busy_o, 1);
        end
    end

    task automatic start_run(input int id, input logic hold);
        wr_cnt = 0; done_seen = 0; tbl_hits = 0; run_id = id;
        build_expected();
        t0 = cnt + 1;
        run_active = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_seen == 0 && k < 1300) begin
            @(negedge clk_i);
            k++;
        end
        if (done_seen == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic end_checks();
        chk("rdq_drained", rdq.size(), 0);
        chk("wrq_drained", wrq.size(), 0);
        chk("write_count", wr_cnt, 1024);
        chk("done_pulses", done_seen, 1);
        chk("table_hits", tbl_hits, 7);
        chk("idle_busy", busy_o, 0);
        for (int k = 0; k < 256; k++) chk("ram_word", mem[k], gold[k]);
        run_active = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) twrom[k] = 32'd1;
        repeat (3) @(negedge clk_i);
        chk("rst_ctrl", {busy_o, done_o, rd_en_o, wr_en_o}, 0);
        chk("rst_rd_addr", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, 0);
        chk("rst_bu", |{bu_data1_o, bu_data2_o, bu_w_o}, 0);
        chk("rst_wr", |{wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o}, 0);
        reset_ni = 1'b1;
        mon_en = 1'b1;

        // Run 1: mem[k]=k, w=1, single start pulse plus a stray pulse at cycle 500.
        pat = 0; load_req = 1'b1;
        @(negedge clk_i); load_req = 1'b0;
        start_run(1, 1'b0);
        while (cnt + 1 - t0 < 500) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        wait_done();
        repeat (5) @(negedge clk_i);
        end_checks();

        // Run 2: aborted by reset at cycle 300.
        for (int k = 0; k < 256; k++) twrom[k] = 32'((k * 1753 + 11) % QM);
        pat = 1; load_req = 1'b1;
        @(negedge clk_i); load_req = 1'b0;
        start_run(2, 1'b0);
        while (cnt + 1 - t0 < 300) @(negedge clk_i);
        #2;
        mon_en = 1'b0; run_active = 1'b0;
        reset_ni = 1'b0;
        #1;
        chk("abort_ctrl", {busy_o, done_o, rd_en_o, wr_en_o}, 0);
        chk("abort_rd_addr", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, 0);
        chk("abort_bu", |{bu_data1_o, bu_data2_o, bu_w_o}, 0);
        chk("abort_wr", |{wr_addr_a_o, wr_addr_b_o, wr_data_a_o, wr_data_b_o}, 0);
        rdq.delete(); wrq.delete();
        repeat (3) @(negedge clk_i);
        reset_ni = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("idle_after_reset", {busy_o, rd_en_o, wr_en_o}, 0);

        // Run 3: start held high over the partial RAM contents, including FINISH.
        start_run(3, 1'b1);
        wait_done();
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        end_checks();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
